// File: rtl/sipo_pkg.sv
// Shared helpers and shift-order encoding for the framed SIPO deserialiser.
package sipo_pkg;

    localparam bit SIPO_MSB_FIRST = 1'b1;
    localparam bit SIPO_LSB_FIRST = 1'b0;

    // A one-bit minimum keeps the counter port legal for the smallest words.
    function automatic int sipo_cw(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/sipo_hold_reg.sv
// Output holding register: accepts emitted words under valid/ready and flags dropped words.
module sipo_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             emit,
    input  logic [WIDTH-1:0] word,
    input  logic             dout_ready,
    input  logic             ovr_clr,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             overrun
);

    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             slot_free;

    assign slot_free = !valid_q || dout_ready;

    always_comb begin
        dout_d  = dout_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (ovr_clr) begin
            ovr_d = 1'b0;
        end
        if (emit) begin
            if (slot_free) begin
                dout_d  = word;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && dout_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign overrun    = ovr_q;

endmodule

// File: rtl/sipo_framed.sv
// Serial-in/parallel-out deserialiser with flush of partial words and handshaked output.
module sipo_framed
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = SIPO_MSB_FIRST
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       din,
    input  logic                       din_valid,
    input  logic                       flush,
    input  logic                       dout_ready,
    input  logic                       ovr_clr,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_valid,
    output logic [sipo_cw(WIDTH)-1:0]  bit_count,
    output logic                       overrun
);

    localparam int CW = sipo_cw(WIDTH);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW:0]      eff_cnt;
    logic [CW:0]      shamt;
    logic             complete;
    logic             flush_emit;
    logic             emit;
    logic [WIDTH-1:0] word;

    always_comb begin
        sr_d = sr_q;
        if (din_valid) begin
            if (MSB_FIRST == SIPO_MSB_FIRST) begin
                sr_d = {sr_q[WIDTH-2:0], din};
            end else begin
                sr_d = {din, sr_q[WIDTH-1:1]};
            end
        end
    end

    // eff_cnt is one bit wider so it can hold WIDTH on the completing bit.
    assign eff_cnt    = {1'b0, cnt_q} + {{CW{1'b0}}, din_valid};
    assign complete   = din_valid && (cnt_q == CW'(WIDTH - 1));
    assign flush_emit = flush && !complete && (eff_cnt != '0);
    assign emit       = complete || flush_emit;
    assign shamt      = (CW + 1)'(WIDTH) - eff_cnt;

    // Shifting out the unreceived positions also discards stale register contents.
    always_comb begin
        word = sr_d;
        if (!complete) begin
            if (MSB_FIRST == SIPO_MSB_FIRST) begin
                word = sr_d << shamt;
            end else begin
                word = sr_d >> shamt;
            end
        end
    end

    always_comb begin
        cnt_d = eff_cnt[CW-1:0];
        if (emit) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign bit_count = cnt_q;

    sipo_hold_reg #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk        (clk),
        .rst        (rst),
        .emit       (emit),
        .word       (word),
        .dout_ready (dout_ready),
        .ovr_clr    (ovr_clr),
        .dout       (dout),
        .dout_valid (dout_valid),
        .overrun    (overrun)
    );

endmodule

// File: tb/tb_sipo_framed.sv
// Directed checks of sipo_framed in both shift orders, driven from one shared stimulus.
module tb_sipo_framed;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       flush = 1'b0;
    logic       dout_ready = 1'b1;
    logic       ovr_clr = 1'b0;

    logic [7:0] m_dout, l_dout;
    logic       m_valid, l_valid;
    logic [2:0] m_cnt, l_cnt;
    logic       m_ovr, l_ovr;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    sipo_framed #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .flush(flush),
        .dout_ready(dout_ready), .ovr_clr(ovr_clr), .dout(m_dout),
        .dout_valid(m_valid), .bit_count(m_cnt), .overrun(m_ovr)
    );

    sipo_framed #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .flush(flush),
        .dout_ready(dout_ready), .ovr_clr(ovr_clr), .dout(l_dout),
        .dout_valid(l_valid), .bit_count(l_cnt), .overrun(l_ovr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            din       = v[i];
            din_valid = 1'b1;
            tick();
        end
        din_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] stream [3];
        logic [7:0] stream_rev [3];
        int pulses;
        stream     = '{8'h11, 8'h22, 8'h33};
        stream_rev = '{8'h88, 8'h44, 8'hCC};

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_dout", {24'd0, m_dout}, 32'h0);
        chk("rst_valid", {31'd0, m_valid}, 32'h0);
        chk("rst_cnt", {29'd0, m_cnt}, 32'h0);
        chk("rst_ovr", {31'd0, m_ovr}, 32'h0);

        // 0xA5 is a bit palindrome, so both orders should yield 0xA5
        send_byte(8'hA5);
        chk("a5_msb_dout", {24'd0, m_dout}, 32'hA5);
        chk("a5_lsb_dout", {24'd0, l_dout}, 32'hA5);
        chk("a5_valid", {31'd0, m_valid}, 32'h1);
        chk("a5_cnt", {29'd0, m_cnt}, 32'h0);
        tick();
        chk("a5_valid_drop", {31'd0, m_valid}, 32'h0);
        chk("a5_lsb_valid_drop", {31'd0, l_valid}, 32'h0);

        for (int i = 7; i >= 0; i--) begin
            logic [7:0] v;
            v = 8'hA5;
            din       = v[i];
            din_valid = 1'b1;
            tick();
            if (i != 0) begin
                chk("gap_no_early_valid", {31'd0, l_valid}, 32'h0);
                din       = ~v[i];
                din_valid = 1'b0;
                tick();
            end
        end
        din_valid = 1'b0;
        chk("gap_lsb_dout", {24'd0, l_dout}, 32'hA5);
        chk("gap_lsb_valid", {31'd0, l_valid}, 32'h1);
        chk("gap_msb_dout", {24'd0, m_dout}, 32'hA5);
        tick();

        dout_ready = 1'b0;
        send_byte(8'h3C);
        chk("hold_first_dout", {24'd0, m_dout}, 32'h3C);
        chk("hold_first_ovr", {31'd0, m_ovr}, 32'h0);
        send_byte(8'hF0);
        chk("hold_keep_dout", {24'd0, m_dout}, 32'h3C);
        chk("hold_keep_valid", {31'd0, m_valid}, 32'h1);
        chk("hold_ovr_set", {31'd0, m_ovr}, 32'h1);
        ovr_clr    = 1'b1;
        dout_ready = 1'b1;
        tick();
        ovr_clr = 1'b0;
        chk("ovr_cleared", {31'd0, m_ovr}, 32'h0);
        chk("hold_valid_drop", {31'd0, m_valid}, 32'h0);
        chk("hold_dout_kept", {24'd0, m_dout}, 32'h3C);

        din = 1'b1; din_valid = 1'b1; tick();
        din = 1'b1; tick();
        din = 1'b0; tick();
        din_valid = 1'b0;
        chk("flush_pre_cnt", {29'd0, m_cnt}, 32'h3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_msb_dout", {24'd0, m_dout}, 32'hC0);
        chk("flush_lsb_dout", {24'd0, l_dout}, 32'h03);
        chk("flush_valid", {31'd0, m_valid}, 32'h1);
        chk("flush_cnt", {29'd0, m_cnt}, 32'h0);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_empty_noop", {31'd0, m_valid}, 32'h0);
        chk("flush_empty_lsb", {31'd0, l_valid}, 32'h0);

        // bit arriving with flush is shifted in before the partial word is formed
        din = 1'b1; din_valid = 1'b1; tick();
        din = 1'b0; tick();
        din = 1'b1; flush = 1'b1; tick();
        din_valid = 1'b0; flush = 1'b0;
        chk("flush_same_msb", {24'd0, m_dout}, 32'hA0);
        chk("flush_same_lsb", {24'd0, l_dout}, 32'h05);
        chk("flush_same_cnt", {29'd0, l_cnt}, 32'h0);
        tick();

        for (int i = 0; i < 5; i++) begin
            din = 1'b1; din_valid = 1'b1; tick();
        end
        din_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_cnt", {29'd0, m_cnt}, 32'h0);
        send_byte(8'h81);
        chk("midrst_msb_dout", {24'd0, m_dout}, 32'h81);
        chk("midrst_lsb_dout", {24'd0, l_dout}, 32'h81);
        chk("midrst_ovr", {31'd0, m_ovr}, 32'h0);
        tick();

        pulses = 0;
        for (int w = 0; w < 3; w++) begin
            for (int i = 7; i >= 0; i--) begin
                din       = stream[w][i];
                din_valid = 1'b1;
                tick();
                if (m_valid) pulses++;
                if (i == 0) begin
                    chk("stream_msb_dout", {24'd0, m_dout}, {24'd0, stream[w]});
                    chk("stream_lsb_dout", {24'd0, l_dout}, {24'd0, stream_rev[w]});
                end
            end
        end
        din_valid = 1'b0;
        chk("stream_pulses", pulses, 32'd3);
        chk("stream_msb_ovr", {31'd0, m_ovr}, 32'h0);
        chk("stream_lsb_ovr", {31'd0, l_ovr}, 32'h0);
        tick();
        chk("stream_end_valid", {31'd0, m_valid}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
